// File: rtl/acc_reg_pkg.sv
// Shared opcode encoding and the width-generic result helper for the accumulator register bank.
package acc_reg_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_LOAD = 3'd1,
    OP_CLR  = 3'd2,
    OP_INC  = 3'd3,
    OP_DEC  = 3'd4,
    OP_SHL  = 3'd5,
    OP_SHR  = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

  // Returns {C, R} for a register of 'width' bits carried in a MAX_W container.
  function automatic logic [MAX_W:0] acc_op_eval(input op_e op,
                                                 input logic [MAX_W-1:0] v,
                                                 input logic [MAX_W-1:0] din,
                                                 input int width);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] vm;
    logic [MAX_W-1:0] hi;
    logic [MAX_W-1:0] r;
    logic             c;
    mask = (width >= MAX_W) ? {MAX_W{1'b1}} : ((64'd1 << width) - 64'd1);
    vm   = v & mask;
    hi   = vm >> (width - 1);
    r    = vm;
    c    = 1'b0;
    case (op)
      OP_LOAD: begin r = din;          c = 1'b0;                    end
      OP_CLR:  begin r = {MAX_W{1'b0}}; c = 1'b0;                   end
      OP_INC:  begin r = vm + 64'd1;   c = (vm == mask);            end
      OP_DEC:  begin r = vm - 64'd1;   c = (vm == {MAX_W{1'b0}});   end
      OP_SHL:  begin r = vm << 1;      c = hi[0];                   end
      OP_SHR:  begin r = vm >> 1;      c = vm[0];                   end
      default: begin r = vm;           c = 1'b0;                    end
    endcase
    return {c, r & mask};
  endfunction

endpackage

// File: rtl/acc_reg_bank_op_unit.sv
// Combinational op evaluator: result, carry and execute strobe for the addressed register.
module acc_op_unit
  import acc_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] v,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] r,
  output logic             c,
  output logic             exec
);

  logic [MAX_W:0] res;
  logic [MAX_W:0] res_unused;

  // Result/carry through the package helper; exec flags the ops that write.
  always_comb begin
    res        = acc_op_eval(op_e'(op), MAX_W'(v), MAX_W'(data_in), WIDTH);
    res_unused = res;
    r          = res[WIDTH-1:0];
    c          = res[MAX_W];
    case (op_e'(op))
      OP_LOAD, OP_CLR, OP_INC, OP_DEC, OP_SHL, OP_SHR: exec = 1'b1;
      default:                                         exec = 1'b0;
    endcase
  end

endmodule

// File: rtl/acc_reg_bank.sv
// NUM_REGS x WIDTH register bank with one opcode-driven write per clock,
// two combinational read ports and registered zero/carry flags.
module acc_reg_bank
  import acc_reg_pkg::*;
#(
  parameter int                WIDTH     = 8,
  parameter int                NUM_REGS  = 4,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  localparam int               SEL_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       op,
  input  logic [SEL_W-1:0] wr_sel,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0] rd_sel_a,
  input  logic [SEL_W-1:0] rd_sel_b,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             zero_flag,
  output logic             carry_flag
);

  localparam logic [SEL_W:0] NUM_REGS_L = NUM_REGS[SEL_W:0];

  logic [WIDTH-1:0] regs_q [NUM_REGS];
  logic [WIDTH-1:0] regs_d [NUM_REGS];
  logic             zero_flag_q, zero_flag_d;
  logic             carry_flag_q, carry_flag_d;

  logic             wr_valid_s;
  logic [WIDTH-1:0] cur_v_s;
  logic [WIDTH-1:0] res_s;
  logic             carry_s;
  logic             exec_s;

  // Out-of-range write indices (non-power-of-2 depth) must not touch anything.
  always_comb begin
    wr_valid_s = ({1'b0, wr_sel} < NUM_REGS_L);
    if (wr_valid_s) begin
      cur_v_s = regs_q[wr_sel];
    end else begin
      cur_v_s = '0;
    end
  end

  acc_op_unit #(.WIDTH(WIDTH)) u_op (
    .op      (op),
    .v       (cur_v_s),
    .data_in (data_in),
    .r       (res_s),
    .c       (carry_s),
    .exec    (exec_s)
  );

  // Next state: reset wins over any op presented in the same cycle.
  always_comb begin
    regs_d       = regs_q;
    zero_flag_d  = zero_flag_q;
    carry_flag_d = carry_flag_q;
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_d[i] = RESET_VAL;
      end
      zero_flag_d  = 1'b0;
      carry_flag_d = 1'b0;
    end else if (wr_valid_s && exec_s) begin
      regs_d[wr_sel] = res_s;
      zero_flag_d    = (res_s == '0);
      carry_flag_d   = carry_s;
    end else begin
      zero_flag_d  = zero_flag_q;
      carry_flag_d = carry_flag_q;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    regs_q       <= regs_d;
    zero_flag_q  <= zero_flag_d;
    carry_flag_q <= carry_flag_d;
  end

  // Read ports see pre-edge contents; out-of-range selects read as zero.
  always_comb begin
    if ({1'b0, rd_sel_a} < NUM_REGS_L) begin
      out_a = regs_q[rd_sel_a];
    end else begin
      out_a = '0;
    end
    if ({1'b0, rd_sel_b} < NUM_REGS_L) begin
      out_b = regs_q[rd_sel_b];
    end else begin
      out_b = '0;
    end
  end

  assign zero_flag  = zero_flag_q;
  assign carry_flag = carry_flag_q;

endmodule

// File: tb/tb_acc_reg_bank.sv
// Scoreboard bench for acc_reg_bank: a 4-register and a 3-register instance,
// directed vectors with hand-computed post-edge expectations.
module tb_acc_reg_bank;

  typedef struct {
    string      name;
    bit         u3;
    logic [7:0] a;
    logic [7:0] b;
    logic       z;
    logic       c;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [2:0] op4, op3;
  logic [1:0] wr_sel, rd_sel_a, rd_sel_b;
  logic [7:0] data_in;
  logic [7:0] out_a4, out_b4, out_a3, out_b3;
  logic       z4, c4, z3, c3;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  acc_reg_bank #(.WIDTH(8), .NUM_REGS(4)) dut4 (
    .clk(clk), .reset(reset), .op(op4), .wr_sel(wr_sel), .data_in(data_in),
    .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b), .out_a(out_a4), .out_b(out_b4),
    .zero_flag(z4), .carry_flag(c4)
  );

  acc_reg_bank #(.WIDTH(8), .NUM_REGS(3)) dut3 (
    .clk(clk), .reset(reset), .op(op3), .wr_sel(wr_sel), .data_in(data_in),
    .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b), .out_a(out_a3), .out_b(out_b3),
    .zero_flag(z3), .carry_flag(c3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One cycle of stimulus; the expectation describes the state after the next posedge.
  task automatic step(input string nm, input bit rst, input bit u3, input logic [2:0] o,
                      input logic [1:0] ws, input logic [7:0] d,
                      input logic [1:0] ra, input logic [1:0] rb,
                      input logic [7:0] ea, input logic [7:0] eb,
                      input logic ez, input logic ec);
    exp_t e;
    @(negedge clk);
    reset    = rst;
    op4      = u3 ? 3'd0 : o;
    op3      = u3 ? o : 3'd0;
    wr_sel   = ws;
    data_in  = d;
    rd_sel_a = ra;
    rd_sel_b = rb;
    e.name = nm; e.u3 = u3; e.a = ea; e.b = eb; e.z = ez; e.c = ec;
    exp_q.push_back(e);
  endtask

  // Monitor: pops one expectation per clock and compares the selected instance.
  initial begin
    exp_t e;
    logic [7:0] aa, bb;
    logic zz, cc;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        aa = e.u3 ? out_a3 : out_a4;
        bb = e.u3 ? out_b3 : out_b4;
        zz = e.u3 ? z3 : z4;
        cc = e.u3 ? c3 : c4;
        n_cmp++;
        if (aa !== e.a || bb !== e.b || zz !== e.z || cc !== e.c) begin
          n_bad++;
          $display("FAIL %s: got a=%h b=%h z=%b c=%b, want a=%h b=%h z=%b c=%b",
                   e.name, aa, bb, zz, cc, e.a, e.b, e.z, e.c);
        end
      end
    end
  end

  initial begin
    int budget;
    reset = 1'b1; op4 = 3'd0; op3 = 3'd0; wr_sel = 2'd0; data_in = 8'h00;
    rd_sel_a = 2'd0; rd_sel_b = 2'd0;

    //   name          rst u3 op    ws     din    ra     rb     a      b      z     c
    step("rst0",       1, 0, 3'd0, 2'd0, 8'h00, 2'd0, 2'd1, 8'h00, 8'h00, 1'b0, 1'b0);
    // Three-register instance: index 3 is out of range for writes and reads.
    step("n3_load2",   0, 1, 3'd1, 2'd2, 8'h5A, 2'd2, 2'd0, 8'h5A, 8'h00, 1'b0, 1'b0);
    step("n3_load0",   0, 1, 3'd1, 2'd0, 8'hFF, 2'd0, 2'd2, 8'hFF, 8'h5A, 1'b0, 1'b0);
    step("n3_inc0",    0, 1, 3'd3, 2'd0, 8'h00, 2'd0, 2'd2, 8'h00, 8'h5A, 1'b1, 1'b1);
    step("n3_ld_oob",  0, 1, 3'd1, 2'd3, 8'h77, 2'd3, 2'd2, 8'h00, 8'h5A, 1'b1, 1'b1);
    step("n3_shr_oob", 0, 1, 3'd6, 2'd3, 8'h00, 2'd0, 2'd1, 8'h00, 8'h00, 1'b1, 1'b1);
    step("n3_inc_oob", 0, 1, 3'd3, 2'd3, 8'h00, 2'd2, 2'd3, 8'h5A, 8'h00, 1'b1, 1'b1);
    // Load, read two ports, reset clears everything.
    step("load2_a5",   0, 0, 3'd1, 2'd2, 8'hA5, 2'd2, 2'd0, 8'hA5, 8'h00, 1'b0, 1'b0);
    step("rst_clr",    1, 0, 3'd0, 2'd0, 8'h00, 2'd2, 2'd3, 8'h00, 8'h00, 1'b0, 1'b0);
    step("post_rst",   0, 0, 3'd0, 2'd0, 8'h00, 2'd0, 2'd1, 8'h00, 8'h00, 1'b0, 1'b0);
    // Increment wrap and decrement borrow.
    step("load1_ff",   0, 0, 3'd1, 2'd1, 8'hFF, 2'd1, 2'd2, 8'hFF, 8'h00, 1'b0, 1'b0);
    step("inc1_wrap",  0, 0, 3'd3, 2'd1, 8'h00, 2'd1, 2'd2, 8'h00, 8'h00, 1'b1, 1'b1);
    step("dec1_borr",  0, 0, 3'd4, 2'd1, 8'h00, 2'd1, 2'd2, 8'hFF, 8'h00, 1'b0, 1'b1);
    // Shifts and shifted-out bits.
    step("load3_81",   0, 0, 3'd1, 2'd3, 8'h81, 2'd3, 2'd1, 8'h81, 8'hFF, 1'b0, 1'b0);
    step("shl3",       0, 0, 3'd5, 2'd3, 8'h00, 2'd3, 2'd1, 8'h02, 8'hFF, 1'b0, 1'b1);
    step("shr3_a",     0, 0, 3'd6, 2'd3, 8'h00, 2'd3, 2'd1, 8'h01, 8'hFF, 1'b0, 1'b0);
    step("shr3_b",     0, 0, 3'd6, 2'd3, 8'h00, 2'd3, 2'd1, 8'h00, 8'hFF, 1'b1, 1'b1);
    // No write bypass, NOP and reserved opcode hold everything.
    step("nop_hold",   0, 0, 3'd0, 2'd3, 8'h55, 2'd0, 2'd3, 8'h00, 8'h00, 1'b1, 1'b1);
    step("load0_3c",   0, 0, 3'd1, 2'd0, 8'h3C, 2'd0, 2'd3, 8'h3C, 8'h00, 1'b0, 1'b0);
    step("rsvd_op",    0, 0, 3'd7, 2'd0, 8'hFF, 2'd0, 2'd1, 8'h3C, 8'hFF, 1'b0, 1'b0);
    step("nop_op",     0, 0, 3'd0, 2'd1, 8'h00, 2'd0, 2'd1, 8'h3C, 8'hFF, 1'b0, 1'b0);
    step("dec3_zero",  0, 0, 3'd4, 2'd3, 8'h00, 2'd3, 2'd0, 8'hFF, 8'h3C, 1'b0, 1'b1);
    step("clr0",       0, 0, 3'd2, 2'd0, 8'h00, 2'd0, 2'd3, 8'h00, 8'hFF, 1'b1, 1'b0);
    // Reset concurrent with an INC: the INC is lost.
    step("load2_10",   0, 0, 3'd1, 2'd2, 8'h10, 2'd2, 2'd0, 8'h10, 8'h00, 1'b0, 1'b0);
    step("inc1_ff",    0, 0, 3'd3, 2'd1, 8'h00, 2'd1, 2'd2, 8'h00, 8'h10, 1'b1, 1'b1);
    step("rst_inc2",   1, 0, 3'd3, 2'd2, 8'h00, 2'd2, 2'd1, 8'h00, 8'h00, 1'b0, 1'b0);
    step("post_rst2",  0, 0, 3'd0, 2'd0, 8'h00, 2'd0, 2'd3, 8'h00, 8'h00, 1'b0, 1'b0);

    @(negedge clk);
    reset = 1'b0; op4 = 3'd0; op3 = 3'd0;
    budget = 10;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
